pc_sequencer: RTL and testbench

Program-counter sequencer for the 16-bit microprocessor. Owns the Load/in inputs of the PC register and decides, once per instruction, the next PC: increment, relative branch, absolute jump, call/return through an internal return-address stack, and (optionally) interrupt entry. Sits between the decoder/control unit and the PC register, and handshakes with instruction memory for fetch.

---
 rtl/pc_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next PC each instruction and owns a small return-address stack.
// Optional interrupt entry is compiled in with `define PC_SEQ_IRQ_EN.
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0010,
  parameter int          STACK_DEPTH  = 4
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [15:0] pc_cur,
  input  logic        mem_ready,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [7:0]  br_off,
  input  logic        jmp_req,
  input  logic        call_req,
  input  logic        ret_req,
  input  logic        reti_req,
  input  logic        halt_req,
  input  logic [15:0] tgt,
  input  logic        irq,
  output logic        pc_load,
  output logic [15:0] pc_in,
  output logic        fetch_req,
  output logic        irq_ack,
  output logic        halted,
  output logic        err_ovf,
  output logic        err_udf
);
  // state | meaning
  // INIT  | load RESET_VECTOR into the PC register
  // FETCH | request instruction, wait for mem_ready
  // EXEC  | decide next PC (held while stall)
  // HALT  | sequencing stopped until reset (or irq when enabled)
  typedef enum logic [1:0] {INIT, FETCH, EXEC, HALT} state_t;

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);

  state_t         state, state_nxt;
  logic [SPW-1:0] sp;
  logic [15:0]    stack_mem [STACK_DEPTH];
  logic [15:0]    stack_top, push_data, pc_inc, pc_br;
  logic           stack_full, stack_empty;
  logic           push, pop, set_ovf, set_udf;

  assign stack_full  = (sp == SPW'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign stack_top   = stack_mem[IW'(sp - 1'b1)];
  assign pc_inc      = pc_cur + 16'd1;
  assign pc_br       = pc_inc + {{8{br_off[7]}}, br_off};

`ifdef PC_SEQ_IRQ_EN
  logic in_isr, set_isr, clr_isr;
`else
  logic unused_irq;
  assign unused_irq = ^{irq, IRQ_VECTOR};
`endif

  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    pc_in     = 16'h0000;
    fetch_req = 1'b0;
    halted    = 1'b0;
    irq_ack   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_inc;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
`ifdef PC_SEQ_IRQ_EN
    set_isr   = 1'b0;
    clr_isr   = 1'b0;
`endif
    if (!reset) begin
      case (state)
        INIT: begin
          pc_load   = 1'b1;
          pc_in     = RESET_VECTOR;
          state_nxt = FETCH;
        end
        FETCH: begin
          fetch_req = 1'b1;
          if (mem_ready) state_nxt = EXEC;
        end
        EXEC: begin
          if (!stall) begin
            if (halt_req) begin
              state_nxt = HALT;
            end else begin
              pc_load   = 1'b1;
              state_nxt = FETCH;
              if (ret_req || reti_req) begin
                if (stack_empty) begin
                  set_udf = 1'b1;
                  pc_in   = pc_inc;
                end else begin
                  pop   = 1'b1;
                  pc_in = stack_top;
                end
`ifdef PC_SEQ_IRQ_EN
                clr_isr = reti_req;
`endif
              end else if (call_req) begin
                pc_in = tgt;
                if (stack_full) set_ovf = 1'b1;
                else            push    = 1'b1;
              end else if (jmp_req) begin
                pc_in = tgt;
              end else if (br_taken) begin
                pc_in = pc_br;
              end else begin
                pc_in = pc_inc;
              end
`ifdef PC_SEQ_IRQ_EN
              // Instructions that already touch the stack defer the interrupt one instruction.
              if (irq && !in_isr && !stack_full && !(ret_req || reti_req || call_req)) begin
                push      = 1'b1;
                push_data = pc_in;
                pc_in     = IRQ_VECTOR;
                irq_ack   = 1'b1;
                set_isr   = 1'b1;
              end
`endif
            end
          end
        end
        HALT: begin
          halted = 1'b1;
`ifdef PC_SEQ_IRQ_EN
          if (irq) begin
            pc_load   = 1'b1;
            pc_in     = IRQ_VECTOR;
            irq_ack   = 1'b1;
            set_isr   = 1'b1;
            state_nxt = FETCH;
            if (stack_full) set_ovf = 1'b1;
            else            push    = 1'b1;
          end
`endif
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state   <= INIT;
      sp      <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
`ifdef PC_SEQ_IRQ_EN
      in_isr  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (push)     sp <= sp + 1'b1;
      else if (pop) sp <= sp - 1'b1;
      if (set_ovf) err_ovf <= 1'b1;
      if (set_udf) err_udf <= 1'b1;
`ifdef PC_SEQ_IRQ_EN
      if (set_isr)      in_isr <= 1'b1;
      else if (clr_isr) in_isr <= 1'b0;
`endif
    end
  end

  // push is never asserted while full, so sp always indexes a valid slot here
  always_ff @(posedge Clk) begin
    if (push) stack_mem[IW'(sp)] <= push_data;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (default build, interrupt support disabled).
module tb_pc_sequencer;
  logic        Clk = 1'b0, reset = 1'b1;
  logic        mem_ready = 1'b0, stall = 1'b0, br_taken = 1'b0;
  logic        jmp_req = 1'b0, call_req = 1'b0, ret_req = 1'b0, reti_req = 1'b0;
  logic        halt_req = 1'b0, irq = 1'b0;
  logic [15:0] pc_cur = 16'h0, tgt = 16'h0;
  logic [7:0]  br_off = 8'h0;
  logic        pc_load, fetch_req, irq_ack, halted, err_ovf, err_udf;
  logic [15:0] pc_in;
  int          checks = 0, errors = 0;

  pc_sequencer dut (
    .Clk(Clk), .reset(reset), .pc_cur(pc_cur), .mem_ready(mem_ready), .stall(stall),
    .br_taken(br_taken), .br_off(br_off), .jmp_req(jmp_req), .call_req(call_req),
    .ret_req(ret_req), .reti_req(reti_req), .halt_req(halt_req), .tgt(tgt), .irq(irq),
    .pc_load(pc_load), .pc_in(pc_in), .fetch_req(fetch_req), .irq_ack(irq_ack),
    .halted(halted), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] pc;
    logic        br;
    logic [7:0]  off;
    logic        jmp, call, ret, reti, irq;
    logic [15:0] tgt;
    logic [15:0] exp_pc;
    logic        exp_ovf, exp_udf;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic [15:0] pc, input logic br, input logic [7:0] off,
                              input logic jmp, input logic call, input logic ret, input logic reti,
                              input logic irq_v, input logic [15:0] t, input logic [15:0] e,
                              input logic ovf, input logic udf);
    vec_t v;
    v.pc = pc; v.br = br; v.off = off; v.jmp = jmp; v.call = call; v.ret = ret;
    v.reti = reti; v.irq = irq_v; v.tgt = t; v.exp_pc = e; v.exp_ovf = ovf; v.exp_udf = udf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_ctrl();
    stall = 0; br_taken = 0; br_off = 0; jmp_req = 0; call_req = 0;
    ret_req = 0; reti_req = 0; halt_req = 0; irq = 0; tgt = 0;
  endtask

  // From FETCH: present the instruction word so the next cycle is EXEC
  task automatic fetch_to_exec();
    mem_ready = 1;
    @(posedge Clk); #1;
    mem_ready = 0;
  endtask

  initial begin
    //            pc       br  off    jmp cal ret rti irq tgt      exp      ovf udf
    vecs[0]  = mk(16'hFFFF, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    vecs[1]  = mk(16'h0002, 1, 8'hFC, 0, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 0);
    vecs[2]  = mk(16'h0010, 0, 8'h00, 1, 0, 0, 0, 1, 16'h1234, 16'h1234, 0, 0);
    vecs[3]  = mk(16'h0010, 1, 8'h05, 1, 0, 0, 0, 0, 16'h4000, 16'h4000, 0, 0);
    vecs[4]  = mk(16'h0020, 1, 8'h7F, 0, 0, 0, 0, 0, 16'h0000, 16'h00A0, 0, 0);
    vecs[5]  = mk(16'h0020, 0, 8'h7F, 0, 0, 0, 0, 0, 16'h0000, 16'h0021, 0, 0);
    vecs[6]  = mk(16'h0100, 0, 8'h00, 0, 1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0);
    vecs[7]  = mk(16'h0200, 0, 8'h00, 0, 1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0);
    vecs[8]  = mk(16'h0300, 0, 8'h00, 0, 1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0);
    vecs[9]  = mk(16'h0400, 0, 8'h00, 0, 1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0);
    vecs[10] = mk(16'h0500, 0, 8'h00, 0, 1, 0, 0, 0, 16'h1000, 16'h1000, 1, 0);
    vecs[11] = mk(16'h1000, 0, 8'h00, 0, 0, 1, 0, 0, 16'h0000, 16'h0401, 1, 0);
    vecs[12] = mk(16'h1000, 0, 8'h00, 0, 0, 1, 0, 0, 16'h0000, 16'h0301, 1, 0);
    vecs[13] = mk(16'h1000, 0, 8'h00, 0, 0, 0, 1, 0, 16'h0000, 16'h0201, 1, 0);
    vecs[14] = mk(16'h1000, 0, 8'h00, 0, 0, 1, 0, 0, 16'h0000, 16'h0101, 1, 0);
    vecs[15] = mk(16'h1000, 0, 8'h00, 0, 0, 1, 0, 0, 16'h0000, 16'h1001, 1, 1);
    vecs[16] = mk(16'h3000, 0, 8'h00, 0, 1, 1, 0, 0, 16'h5555, 16'h3001, 1, 1);

    // reset state
    @(negedge Clk);
    check("rst_pc_load", pc_load, 0);
    check("rst_pc_in", pc_in, 16'h0000);
    check("rst_fetch_req", fetch_req, 0);
    check("rst_halted", halted, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_err_udf", err_udf, 0);
    @(posedge Clk); #1 reset = 0;
    @(negedge Clk);
    check("init_pc_load", pc_load, 1);
    check("init_pc_in", pc_in, 16'h0000);
    check("init_fetch_req", fetch_req, 0);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("first_fetch_req", fetch_req, 1);
    check("fetch_pc_load", pc_load, 0);

    // straight-line sequencing
    for (int i = 0; i < 3; i++) begin
      pc_cur = 16'(i);
      fetch_to_exec();
      @(negedge Clk);
      check("seq_pc_load", pc_load, 1);
      check("seq_pc_in", pc_in, 32'(i + 1));
      @(posedge Clk); #1;
    end

    // table of single instructions, stack state carried between entries
    for (int i = 0; i < 17; i++) begin
      pc_cur = vecs[i].pc;
      fetch_to_exec();
      br_taken = vecs[i].br; br_off = vecs[i].off; jmp_req = vecs[i].jmp;
      call_req = vecs[i].call; ret_req = vecs[i].ret; reti_req = vecs[i].reti;
      irq = vecs[i].irq; tgt = vecs[i].tgt;
      @(negedge Clk);
      check($sformatf("vec%0d_pc_load", i), pc_load, 1);
      check($sformatf("vec%0d_pc_in", i), pc_in, vecs[i].exp_pc);
      check($sformatf("vec%0d_irq_ack", i), irq_ack, 0);
      @(posedge Clk); #1;
      clear_ctrl();
      @(negedge Clk);
      check($sformatf("vec%0d_err_ovf", i), err_ovf, vecs[i].exp_ovf);
      check($sformatf("vec%0d_err_udf", i), err_udf, vecs[i].exp_udf);
      check($sformatf("vec%0d_fetch_req", i), fetch_req, 1);
    end

    // stall holds EXEC with no load
    pc_cur = 16'h0800;
    fetch_to_exec();
    jmp_req = 1; tgt = 16'h2222; stall = 1;
    repeat (3) begin
      @(negedge Clk);
      check("stall_pc_load", pc_load, 0);
      check("stall_fetch_req", fetch_req, 0);
      @(posedge Clk); #1;
    end
    stall = 0;
    @(negedge Clk);
    check("stall_release_pc_load", pc_load, 1);
    check("stall_release_pc_in", pc_in, 16'h2222);
    @(posedge Clk); #1;
    clear_ctrl();

    // leave one entry on the stack, then halt and reset
    pc_cur = 16'h0700;
    fetch_to_exec();
    call_req = 1; tgt = 16'h0900;
    @(negedge Clk);
    check("call_pc_in", pc_in, 16'h0900);
    @(posedge Clk); #1;
    clear_ctrl();
    pc_cur = 16'h0900;
    fetch_to_exec();
    halt_req = 1;
    @(negedge Clk);
    check("halt_pc_load", pc_load, 0);
    @(posedge Clk); #1;
    clear_ctrl();
    mem_ready = 1; jmp_req = 1; tgt = 16'h3333; irq = 1;
    repeat (2) begin
      @(negedge Clk);
      check("halt_halted", halted, 1);
      check("halt_fetch_req", fetch_req, 0);
      check("halt_pc_load", pc_load, 0);
      check("halt_irq_ack", irq_ack, 0);
      @(posedge Clk);
    end
    #1 reset = 1; mem_ready = 0;
    clear_ctrl();
    @(negedge Clk);
    check("rst2_pc_load", pc_load, 0);
    check("rst2_halted", halted, 0);
    @(posedge Clk); #1 reset = 0;
    @(negedge Clk);
    check("rst2_init_pc_load", pc_load, 1);
    check("rst2_init_pc_in", pc_in, 16'h0000);
    check("rst2_err_ovf", err_ovf, 0);
    check("rst2_err_udf", err_udf, 0);
    @(posedge Clk); #1;

    // stack must be empty after reset: ret underflows instead of returning 0x0701
    pc_cur = 16'h0050;
    fetch_to_exec();
    ret_req = 1;
    @(negedge Clk);
    check("post_rst_ret_pc_in", pc_in, 16'h0051);
    @(posedge Clk); #1;
    clear_ctrl();
    @(negedge Clk);
    check("post_rst_ret_udf", err_udf, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
